task_launch_queue: RTL and testbench



---
 rtl/io881_task_pkg.sv | 16 +
 rtl/task_fifo.sv | 49 ++++
 rtl/task_launch_queue.sv | 83 ++++++++
 tb/tb_task_launch_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/io881_task_pkg.sv
// rtl/io881_task_pkg.sv - shared task-launch widths, thread kinds and entry size
package io881_task_pkg;

  localparam int CHAN_SEL_SIZE   = 3;
  localparam int THREAD_SEL_SIZE = 2;
  localparam int OPERAND_SIZE    = 8;
  localparam int TASK_ENTRY_SIZE = CHAN_SEL_SIZE + THREAD_SEL_SIZE + OPERAND_SIZE;

  typedef enum logic [1:0] {
    THREAD_INPUT    = 2'd0,
    THREAD_OUTPUT   = 2'd1,
    THREAD_REQUEST  = 2'd2,
    THREAD_RESERVED = 2'd3
  } thread_e;

endpackage

// File: rtl/task_fifo.sv
// rtl/task_fifo.sv - one task launch queue: wrap-bit pointers, storage, count, gated head
module task_fifo #(
  parameter int WIDTH    = 13,
  parameter int DEPTH    = 8,
  parameter int PTR_SIZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                push,
  input  logic                pop,
  output logic [WIDTH-1:0]    head_data,
  output logic                head_valid,
  output logic                full,
  output logic [PTR_SIZE:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_SIZE:0] wptr;
  logic [PTR_SIZE:0] rptr;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign empty   = (rptr == wptr);
  assign full    = (wptr[PTR_SIZE-1:0] == rptr[PTR_SIZE-1:0]) && (wptr[PTR_SIZE] != rptr[PTR_SIZE]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is deliberately left unreset; emptiness is carried by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PTR_SIZE-1:0]] <= push_data;
  end

  assign count      = wptr - rptr;
  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem[rptr[PTR_SIZE-1:0]];

endmodule

// File: rtl/task_launch_queue.sv
// rtl/task_launch_queue.sv - steers launch requests by channel LSB into two fetcher FIFOs
module task_launch_queue #(
  parameter int CHAN_SEL_SIZE   = io881_task_pkg::CHAN_SEL_SIZE,
  parameter int THREAD_SEL_SIZE = io881_task_pkg::THREAD_SEL_SIZE,
  parameter int OPERAND_SIZE    = io881_task_pkg::OPERAND_SIZE,
  parameter int QUEUE_DEPTH     = 8,
  parameter int PTR_SIZE        = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHAN_SEL_SIZE:0]     req_channel,
  input  logic [THREAD_SEL_SIZE-1:0] req_thread,
  input  logic [OPERAND_SIZE-1:0]    req_operand,
  input  logic                       req_valid,
  output logic                       req_ready,
  output logic [CHAN_SEL_SIZE-1:0]   q0_task_channel,
  output logic [THREAD_SEL_SIZE-1:0] q0_task_thread,
  output logic [OPERAND_SIZE-1:0]    q0_task_operand,
  output logic                       q0_task_ready,
  input  logic                       q0_task_ack,
  output logic [PTR_SIZE:0]          q0_count,
  output logic [CHAN_SEL_SIZE-1:0]   q1_task_channel,
  output logic [THREAD_SEL_SIZE-1:0] q1_task_thread,
  output logic [OPERAND_SIZE-1:0]    q1_task_operand,
  output logic                       q1_task_ready,
  input  logic                       q1_task_ack,
  output logic [PTR_SIZE:0]          q1_count,
  output logic                       bad_req
);

  import io881_task_pkg::*;

  localparam int ENTRY_SIZE = CHAN_SEL_SIZE + THREAD_SEL_SIZE + OPERAND_SIZE;

  logic [ENTRY_SIZE-1:0] req_entry;
  logic [ENTRY_SIZE-1:0] head0;
  logic [ENTRY_SIZE-1:0] head1;
  logic [1:0]            full;
  logic                  reserved;
  logic                  push;

  assign reserved  = (req_thread == THREAD_SEL_SIZE'(THREAD_RESERVED));
  // Held low through reset so no request is taken while the queues are being cleared.
  assign req_ready = !reset && !full[req_channel[0]];
  assign push      = req_valid && req_ready && !reserved;
  assign req_entry = {req_channel[CHAN_SEL_SIZE:1], req_thread, req_operand};

  task_fifo #(.WIDTH(ENTRY_SIZE), .DEPTH(QUEUE_DEPTH), .PTR_SIZE(PTR_SIZE)) u_queue0 (
    .clk        (clk),
    .reset      (reset),
    .push_data  (req_entry),
    .push       (push && !req_channel[0]),
    .pop        (q0_task_ack),
    .head_data  (head0),
    .head_valid (q0_task_ready),
    .full       (full[0]),
    .count      (q0_count)
  );

  task_fifo #(.WIDTH(ENTRY_SIZE), .DEPTH(QUEUE_DEPTH), .PTR_SIZE(PTR_SIZE)) u_queue1 (
    .clk        (clk),
    .reset      (reset),
    .push_data  (req_entry),
    .push       (push && req_channel[0]),
    .pop        (q1_task_ack),
    .head_data  (head1),
    .head_valid (q1_task_ready),
    .full       (full[1]),
    .count      (q1_count)
  );

  assign {q0_task_channel, q0_task_thread, q0_task_operand} = head0;
  assign {q1_task_channel, q1_task_thread, q1_task_operand} = head1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_req <= 1'b0;
    end else if (req_valid && reserved) begin
      bad_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_task_launch_queue.sv
// tb/tb_task_launch_queue.sv - directed self-checking bench for task_launch_queue
module tb_task_launch_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_channel;
  logic [1:0] req_thread;
  logic [7:0] req_operand;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] q0_task_channel, q1_task_channel;
  logic [1:0] q0_task_thread, q1_task_thread;
  logic [7:0] q0_task_operand, q1_task_operand;
  logic       q0_task_ready, q1_task_ready;
  logic       q0_task_ack, q1_task_ack;
  logic [3:0] q0_count, q1_count;
  logic       bad_req;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  task_launch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .req_channel     (req_channel),
    .req_thread      (req_thread),
    .req_operand     (req_operand),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .q0_task_channel (q0_task_channel),
    .q0_task_thread  (q0_task_thread),
    .q0_task_operand (q0_task_operand),
    .q0_task_ready   (q0_task_ready),
    .q0_task_ack     (q0_task_ack),
    .q0_count        (q0_count),
    .q1_task_channel (q1_task_channel),
    .q1_task_thread  (q1_task_thread),
    .q1_task_operand (q1_task_operand),
    .q1_task_ready   (q1_task_ready),
    .q1_task_ack     (q1_task_ack),
    .q1_count        (q1_count),
    .bad_req         (bad_req)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] ch, input logic [1:0] th, input logic [7:0] op);
    req_valid   = v;
    req_channel = ch;
    req_thread  = th;
    req_operand = op;
  endtask

  initial begin
    int pushed;
    int head_exp;
    int max_cnt;
    int cyc;

    reset = 1'b1;
    q0_task_ack = 1'b0;
    q1_task_ack = 1'b0;
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    tick();
    tick();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_q0_count", q0_count, 0);
    check_eq("rst_q1_ready", q1_task_ready, 0);
    check_eq("rst_q0_operand", q0_task_operand, 0);
    check_eq("rst_bad_req", bad_req, 0);
    reset = 1'b0;
    #1;

    // single launch
    set_req(1'b1, 4'd5, 2'd1, 8'h3C);
    check_eq("single_req_ready", req_ready, 1);
    tick();
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    check_eq("single_q1_ready", q1_task_ready, 1);
    check_eq("single_q1_channel", q1_task_channel, 2);
    check_eq("single_q1_thread", q1_task_thread, 1);
    check_eq("single_q1_operand", q1_task_operand, 8'h3C);
    check_eq("single_q1_count", q1_count, 1);
    check_eq("single_q0_count", q0_count, 0);
    q1_task_ack = 1'b1;
    tick();
    q1_task_ack = 1'b0;
    check_eq("single_pop_ready", q1_task_ready, 0);
    check_eq("single_pop_operand", q1_task_operand, 0);
    check_eq("single_pop_channel", q1_task_channel, 0);
    check_eq("single_pop_count", q1_count, 0);

    // fill queue 0
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 4'((i % 4) * 2), 2'd0, 8'(8'h10 + i));
      tick();
    end
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    check_eq("fill_q0_count", q0_count, 8);
    check_eq("fill_ready_even", req_ready, 0);
    req_channel = 4'd1;
    #1;
    check_eq("fill_ready_odd", req_ready, 1);
    check_eq("fill_head", q0_task_operand, 8'h10);
    set_req(1'b1, 4'd0, 2'd0, 8'hAA);
    q0_task_ack = 1'b1;
    #1;
    check_eq("full_pop_push_ready", req_ready, 0);
    tick();
    q0_task_ack = 1'b0;
    check_eq("full_pop_count", q0_count, 7);
    check_eq("full_pop_head", q0_task_operand, 8'h11);
    check_eq("retry_ready", req_ready, 1);
    tick();
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    check_eq("retry_count", q0_count, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_head", q0_task_operand, (i == 7) ? 8'hAA : 8'(8'h11 + i));
      q0_task_ack = 1'b1;
      tick();
    end
    q0_task_ack = 1'b0;
    check_eq("drain_count", q0_count, 0);

    // wrap-around: push when possible, ack every other cycle
    pushed = 0;
    head_exp = 0;
    max_cnt = 0;
    cyc = 0;
    while ((pushed < 20 || q0_task_ready) && cyc < 200) begin
      if (pushed < 20) set_req(1'b1, 4'd2, 2'd2, 8'(pushed));
      else set_req(1'b0, 4'd0, 2'd0, 8'd0);
      q0_task_ack = (cyc % 2 == 1) || (pushed >= 20);
      #1;
      if (q0_task_ack && q0_task_ready) begin
        check_eq("wrap_head", q0_task_operand, head_exp);
        head_exp++;
      end
      if (req_valid && req_ready) pushed++;
      tick();
      if (int'(q0_count) > max_cnt) max_cnt = int'(q0_count);
      cyc++;
    end
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    q0_task_ack = 1'b0;
    check_eq("wrap_pushed", pushed, 20);
    check_eq("wrap_popped", head_exp, 20);
    check_eq("wrap_max_count", max_cnt, 8);
    check_eq("wrap_final_count", q0_count, 0);

    // simultaneous push/pop on queue 1, then cross-queue push/pop
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 4'(2 * i + 1), 2'd2, 8'(8'h21 + i));
      tick();
    end
    check_eq("sim_pre_count", q1_count, 3);
    set_req(1'b1, 4'd7, 2'd2, 8'h24);
    q1_task_ack = 1'b1;
    tick();
    check_eq("sim_count", q1_count, 3);
    check_eq("sim_head_op", q1_task_operand, 8'h22);
    check_eq("sim_head_ch", q1_task_channel, 1);
    check_eq("sim_head_th", q1_task_thread, 2);
    set_req(1'b1, 4'd0, 2'd1, 8'h55);
    tick();
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    q1_task_ack = 1'b0;
    check_eq("cross_q0_count", q0_count, 1);
    check_eq("cross_q1_count", q1_count, 2);
    check_eq("cross_q1_head", q1_task_operand, 8'h23);
    check_eq("cross_q0_head", q0_task_operand, 8'h55);

    // reserved thread
    set_req(1'b1, 4'd0, 2'd3, 8'h99);
    #1;
    check_eq("rsv_req_ready", req_ready, 1);
    tick();
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    check_eq("rsv_q0_count", q0_count, 1);
    check_eq("rsv_q0_head", q0_task_operand, 8'h55);
    check_eq("rsv_bad_req", bad_req, 1);
    tick();
    tick();
    check_eq("rsv_bad_sticky", bad_req, 1);

    // async reset with both queues half full
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 4'd2, 2'd0, 8'(i));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 4'd3, 2'd0, 8'(i));
      tick();
    end
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    check_eq("pre_rst_q0_count", q0_count, 4);
    check_eq("pre_rst_q1_count", q1_count, 4);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_q0_count", q0_count, 0);
    check_eq("arst_q1_count", q1_count, 0);
    check_eq("arst_q0_ready", q0_task_ready, 0);
    check_eq("arst_q1_ready", q1_task_ready, 0);
    check_eq("arst_q1_operand", q1_task_operand, 0);
    check_eq("arst_req_ready", req_ready, 0);
    check_eq("arst_bad_req", bad_req, 0);
    tick();
    reset = 1'b0;
    set_req(1'b1, 4'd1, 2'd1, 8'h77);
    tick();
    set_req(1'b0, 4'd0, 2'd0, 8'd0);
    check_eq("post_rst_q1_count", q1_count, 1);
    check_eq("post_rst_q1_head", q1_task_operand, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
